// File: rtl/mmu_tile_sequencer.sv
// Sequencer for a 3x3 weight-stationary systolic MMU: weight tile load, PE capture,
// activation streaming with a valid-tag pipeline, and re-alignment of skewed column outputs.
module mmu_tile_sequencer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned ARRAY_SIZE = 3
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic                                  use_signed_in,
  output logic                                  busy,
  output logic                                  done,
  input  logic                                  w_valid,
  output logic                                  w_ready,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0]      w_data,
  input  logic                                  a_valid,
  output logic                                  a_ready,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0]      a_data,
  input  logic                                  a_last,
  output logic                                  mmu_en_weight_pass,
  output logic [ARRAY_SIZE*ARRAY_SIZE-1:0]      mmu_en_capture,
  output logic                                  mmu_use_signed,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0]      mmu_row,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0]      mmu_col,
  input  logic [ARRAY_SIZE*ACC_WIDTH-1:0]       mmu_acc,
  output logic                                  r_valid,
  output logic [ARRAY_SIZE*ACC_WIDTH-1:0]       r_data,
  output logic                                  r_last
);

  localparam int unsigned VW = ARRAY_SIZE * DATA_WIDTH;
  localparam int unsigned RW = ARRAY_SIZE * ACC_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WLOAD,
    S_WPASS0,
    S_WPASS1,
    S_WPASS2,
    S_STREAM,
    S_DRAIN
  } state_t;

  state_t                 state_q, state_d;
  logic [VW-1:0]          wbuf_q [3];
  logic [1:0]             wcnt_q;
  logic                   signed_q;
  logic [VW-1:0]          row_q;
  logic [5:0]             tag_q;
  logic [5:0]             last_q;
  logic [ACC_WIDTH-1:0]   acc0_d1_q, acc0_d2_q, acc1_d1_q;
  logic                   r_valid_q, r_last_q, done_q;
  logic [RW-1:0]          r_data_q;

  logic                   start_hs, w_hs, a_hs;
  logic [RW-1:0]          deskewed;

  assign start_hs = (state_q == S_IDLE)   && start;
  assign w_hs     = (state_q == S_WLOAD)  && w_valid;
  assign a_hs     = (state_q == S_STREAM) && a_valid;

  // acc0 leads acc2 by two cycles and acc1 by one; delay the early columns to line them up.
  assign deskewed = {mmu_acc[2*ACC_WIDTH +: ACC_WIDTH], acc1_d1_q, acc0_d2_q};

  always_comb begin
    state_d            = state_q;
    w_ready            = 1'b0;
    a_ready            = 1'b0;
    mmu_en_weight_pass = 1'b0;
    mmu_en_capture     = '0;
    mmu_col            = '0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_WLOAD;
      end
      S_WLOAD: begin
        w_ready = 1'b1;
        if (w_valid && (wcnt_q == 2'd2)) state_d = S_WPASS0;
      end
      S_WPASS0: begin
        mmu_en_weight_pass = 1'b1;
        mmu_col            = wbuf_q[2];
        state_d            = S_WPASS1;
      end
      S_WPASS1: begin
        mmu_en_weight_pass = 1'b1;
        mmu_col            = wbuf_q[1];
        state_d            = S_WPASS2;
      end
      S_WPASS2: begin
        mmu_en_weight_pass = 1'b1;
        mmu_en_capture     = '1;
        mmu_col            = wbuf_q[0];
        state_d            = S_STREAM;
      end
      S_STREAM: begin
        a_ready = 1'b1;
        if (a_valid && a_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (tag_q == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      for (int unsigned i = 0; i < 3; i++) wbuf_q[i] <= '0;
      wcnt_q    <= '0;
      signed_q  <= 1'b0;
      row_q     <= '0;
      tag_q     <= '0;
      last_q    <= '0;
      acc0_d1_q <= '0;
      acc0_d2_q <= '0;
      acc1_d1_q <= '0;
      r_valid_q <= 1'b0;
      r_last_q  <= 1'b0;
      r_data_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_hs) begin
        signed_q <= use_signed_in;
        wcnt_q   <= '0;
      end
      if (w_hs) begin
        wbuf_q[wcnt_q] <= w_data;
        wcnt_q         <= wcnt_q + 2'd1;
      end
      row_q     <= a_hs ? a_data : '0;
      tag_q     <= {tag_q[4:0], a_hs};
      last_q    <= {last_q[4:0], a_hs & a_last};
      acc0_d1_q <= mmu_acc[0 +: ACC_WIDTH];
      acc0_d2_q <= acc0_d1_q;
      acc1_d1_q <= mmu_acc[ACC_WIDTH +: ACC_WIDTH];
      r_valid_q <= tag_q[5];
      r_last_q  <= last_q[5];
      r_data_q  <= tag_q[5] ? deskewed : '0;
      // Registered so done lands one cycle after the final result.
      done_q    <= (state_q == S_DRAIN) && (tag_q == '0);
    end
  end

  assign busy           = (state_q != S_IDLE);
  assign done           = done_q;
  assign mmu_use_signed = signed_q;
  assign mmu_row        = row_q;
  assign r_valid        = r_valid_q;
  assign r_data         = r_data_q;
  assign r_last         = r_last_q;

endmodule

// File: tb/tb_mmu_tile_sequencer.sv
// Directed bench for mmu_tile_sequencer with a behavioural 3x3 MMU model driving mmu_acc.
module tb_mmu_tile_sequencer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, use_signed_in;
  logic         busy, done;
  logic         w_valid, w_ready;
  logic [23:0]  w_data;
  logic         a_valid, a_ready;
  logic [23:0]  a_data;
  logic         a_last;
  logic         mmu_en_weight_pass;
  logic [8:0]   mmu_en_capture;
  logic         mmu_use_signed;
  logic [23:0]  mmu_row, mmu_col;
  logic [95:0]  mmu_acc;
  logic         r_valid;
  logic [95:0]  r_data;
  logic         r_last;

  mmu_tile_sequencer #(.DATA_WIDTH(8), .ACC_WIDTH(32), .ARRAY_SIZE(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .use_signed_in(use_signed_in),
    .busy(busy), .done(done),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_last(a_last),
    .mmu_en_weight_pass(mmu_en_weight_pass), .mmu_en_capture(mmu_en_capture),
    .mmu_use_signed(mmu_use_signed), .mmu_row(mmu_row), .mmu_col(mmu_col),
    .mmu_acc(mmu_acc), .r_valid(r_valid), .r_data(r_data), .r_last(r_last)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // MMU model: weights shift down the psum path, capture latches them; acc_c follows row by 3+c cycles.
  logic [7:0]  wm [3][3] = '{default: '0};
  logic [23:0] p0 = '0, p1 = '0;
  logic [23:0] hist [6] = '{default: '0};

  always @(posedge clk) begin
    if (mmu_en_weight_pass) begin
      p0 <= mmu_col;
      p1 <= p0;
    end
    if (mmu_en_capture == 9'h1FF) begin
      for (int c = 0; c < 3; c++) begin
        wm[0][c] <= mmu_col[c*8 +: 8];
        wm[1][c] <= p0[c*8 +: 8];
        wm[2][c] <= p1[c*8 +: 8];
      end
    end
    hist[0] <= mmu_row;
    for (int k = 1; k < 6; k++) hist[k] <= hist[k-1];
  end

  function automatic logic [31:0] ext(input logic [7:0] x, input logic sg);
    return sg ? {{24{x[7]}}, x} : {24'd0, x};
  endfunction

  always_comb begin
    logic [31:0] s;
    logic [23:0] rv;
    mmu_acc = '0;
    for (int c = 0; c < 3; c++) begin
      s  = '0;
      rv = hist[2+c];
      for (int r = 0; r < 3; r++)
        s = s + ext(rv[r*8 +: 8], mmu_use_signed) * ext(wm[r][c], mmu_use_signed);
      mmu_acc[c*32 +: 32] = s;
    end
  end

  // Result monitor, sampled on the falling edge.
  int unsigned obs_cyc [$];
  logic [95:0] obs_data [$];
  logic        obs_last [$];
  always @(negedge clk) begin
    if (r_valid) begin
      obs_cyc.push_back(cyc);
      obs_data.push_back(r_data);
      obs_last.push_back(r_last);
    end
  end

  int unsigned exp_cyc [$];
  logic [95:0] exp_data [$];
  logic        exp_last [$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_weights(input logic sg, input logic [23:0] w0, input logic [23:0] w1,
                              input logic [23:0] w2);
    start = 1'b1; use_signed_in = sg;
    step();
    start = 1'b0; use_signed_in = ~sg;
    chk("busy_after_start", busy, 1);
    chk("w_ready_wload", w_ready, 1);
    chk("signed_latched", mmu_use_signed, sg);
    w_valid = 1'b1; w_data = w0; step();
    w_data = w1; step();
    w_data = w2; step();
    w_valid = 1'b0; w_data = '0;
    chk("wpass0_col", mmu_col, w2);
    chk("wpass0_ctl", {mmu_en_weight_pass, mmu_en_capture, mmu_row}, {1'b1, 9'h000, 24'h0});
    step();
    chk("wpass1_col", mmu_col, w1);
    chk("wpass1_ctl", {mmu_en_weight_pass, mmu_en_capture}, {1'b1, 9'h000});
    step();
    chk("wpass2_col", mmu_col, w0);
    chk("wpass2_ctl", {mmu_en_weight_pass, mmu_en_capture}, {1'b1, 9'h1FF});
    step();
    chk("stream_ctl", {a_ready, mmu_en_weight_pass, mmu_en_capture, mmu_col}, {1'b1, 1'b0, 9'h000, 24'h0});
  endtask

  task automatic send(input logic [23:0] d, input logic last, input logic [95:0] expv);
    chk("a_ready_stream", a_ready, 1);
    a_valid = 1'b1; a_data = d; a_last = last;
    exp_cyc.push_back(cyc + 7);
    exp_data.push_back(expv);
    exp_last.push_back(last);
    step();
    a_valid = 1'b0; a_data = '0; a_last = 1'b0;
    chk("mmu_row_drive", mmu_row, d);
  endtask

  task automatic finish_job(input string name);
    int n = 0;
    int unsigned done_exp;
    done_exp = exp_cyc[exp_cyc.size()-1] + 1;
    chk({name, "_a_ready_drain"}, a_ready, 0);
    while (!done && n < 40) begin
      step();
      n++;
    end
    chk({name, "_done_seen"}, done, 1);
    chk({name, "_done_cycle"}, cyc, done_exp);
    chk({name, "_busy_low"}, busy, 0);
    step();
    chk({name, "_done_pulse"}, done, 0);
    chk({name, "_result_count"}, obs_cyc.size(), exp_cyc.size());
    while (exp_cyc.size() > 0 && obs_cyc.size() > 0) begin
      chk({name, "_r_cycle"}, obs_cyc.pop_front(), exp_cyc.pop_front());
      chk({name, "_r_data"}, obs_data.pop_front(), exp_data.pop_front());
      chk({name, "_r_last"}, obs_last.pop_front(), exp_last.pop_front());
    end
    exp_cyc.delete(); exp_data.delete(); exp_last.delete();
    obs_cyc.delete(); obs_data.delete(); obs_last.delete();
  endtask

  localparam logic [23:0] ID0 = {8'd0, 8'd0, 8'd1};
  localparam logic [23:0] ID1 = {8'd0, 8'd1, 8'd0};
  localparam logic [23:0] ID2 = {8'd1, 8'd0, 8'd0};
  localparam logic [23:0] WA0 = {8'd3, 8'd2, 8'd1};
  localparam logic [23:0] WA1 = {8'd6, 8'd5, 8'd4};
  localparam logic [23:0] WA2 = {8'd9, 8'd8, 8'd7};

  initial begin
    rst_n = 1'b0; start = 1'b0; use_signed_in = 1'b0;
    w_valid = 1'b0; w_data = '0; a_valid = 1'b0; a_data = '0; a_last = 1'b0;
    step(); step();
    chk("rst_ctl", {busy, done, w_ready, a_ready, mmu_en_weight_pass, mmu_en_capture,
                    mmu_use_signed, r_valid, r_last}, '0);
    chk("rst_row_col", {mmu_row, mmu_col}, '0);
    chk("rst_r_data", r_data, '0);
    rst_n = 1'b1;
    step();
    chk("idle_busy", busy, 0);

    // Identity weights
    load_weights(1'b0, ID0, ID1, ID2);
    send({8'd3, 8'd2, 8'd1}, 1'b1, {32'd3, 32'd2, 32'd1});
    finish_job("identity");

    // General weights, all-ones vector
    load_weights(1'b0, WA0, WA1, WA2);
    send({8'd1, 8'd1, 8'd1}, 1'b1, {32'd18, 32'd15, 32'd12});
    finish_job("sum");

    // Signed mode, with a start pulse while busy that must be ignored
    load_weights(1'b1, ID0, ID1, ID2);
    start = 1'b1; use_signed_in = 1'b0;
    step();
    start = 1'b0;
    chk("busy_start_ignored", {busy, mmu_use_signed, a_ready}, {1'b1, 1'b1, 1'b1});
    send({8'd0, 8'd2, 8'hFF}, 1'b1, {32'd0, 32'd2, 32'hFFFF_FFFF});
    finish_job("signed");

    // Same vector, unsigned
    load_weights(1'b0, ID0, ID1, ID2);
    send({8'd0, 8'd2, 8'hFF}, 1'b1, {32'd0, 32'd2, 32'd255});
    finish_job("unsigned");

    // Four vectors with a two-cycle gap after the second
    load_weights(1'b0, WA0, WA1, WA2);
    send({8'd0, 8'd0, 8'd1}, 1'b0, {32'd3, 32'd2, 32'd1});
    send({8'd0, 8'd1, 8'd0}, 1'b0, {32'd6, 32'd5, 32'd4});
    step(); step();
    send({8'd1, 8'd0, 8'd0}, 1'b0, {32'd9, 32'd8, 32'd7});
    send({8'd1, 8'd1, 8'd2}, 1'b1, {32'd21, 32'd17, 32'd13});
    finish_job("burst");

    // Reset with results in flight
    load_weights(1'b1, ID0, ID1, ID2);
    send({8'd3, 8'd2, 8'd1}, 1'b0, {32'd3, 32'd2, 32'd1});
    send({8'd6, 8'd5, 8'd4}, 1'b0, {32'd6, 32'd5, 32'd4});
    step(); step();
    rst_n = 1'b0;
    #1;
    chk("midrst_ctl", {busy, done, w_ready, a_ready, mmu_en_weight_pass, mmu_en_capture,
                       mmu_use_signed, r_valid, r_last}, '0);
    chk("midrst_row_col", {mmu_row, mmu_col}, '0);
    chk("midrst_r_data", r_data, '0);
    step(); step();
    exp_cyc.delete(); exp_data.delete(); exp_last.delete();
    obs_cyc.delete(); obs_data.delete(); obs_last.delete();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) step();
    chk("no_r_valid_after_rst", obs_cyc.size(), 0);
    chk("idle_after_rst", busy, 0);
    load_weights(1'b0, ID0, ID1, ID2);
    send({8'd9, 8'd8, 8'd7}, 1'b1, {32'd9, 32'd8, 32'd7});
    finish_job("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
